// File: rtl/spi_slave_shift_engine.sv
// spi_slave_shift_engine: SPI slave data path (synchronisers, CPOL/CPHA strobes, rx/tx shift, one-entry tx holding buffer)
module spi_slave_shift_engine #(
  parameter int DATA_WIDTH = 8,
  parameter int SYNC_STAGES = 2,
  parameter int LSB_FIRST = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  SCK_in,
  input  logic                  SS_n,
  input  logic                  MOSI,
  input  logic                  CPOL,
  input  logic                  CPHA,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  tx_valid,
  output logic                  tx_ready,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_valid,
  output logic                  MISO,
  output logic                  MISO_oe,
  output logic                  busy,
  output logic                  underrun
);
  localparam int CW = $clog2(DATA_WIDTH);
  localparam logic [CW-1:0] LAST = CW'(DATA_WIDTH - 1);
  typedef enum logic {IDLE, ACTIVE} state_t;
  state_t state, state_nxt;
  logic [SYNC_STAGES-1:0] sck_sy, ss_sy, mosi_sy;
  logic sck_s, ss_s, mosi_s, sck_d, ss_d;
  logic sck_rise, sck_fall, ss_fall, ss_rise, lead, trail;
  logic start, stop, sample_stb, shift_stb, load, accept;
  logic cpol_q, cpha_q, hold_full, load_due;
  logic [DATA_WIDTH-1:0] hold_data, tx_shift, rx_shift, rx_nxt;
  logic [CW-1:0] bit_cnt;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      sck_sy <= '0;
      ss_sy <= '1;
      mosi_sy <= '0;
      sck_d <= 1'b0;
      ss_d <= 1'b1;
    end else begin
      sck_sy <= {sck_sy[SYNC_STAGES-2:0], SCK_in};
      ss_sy <= {ss_sy[SYNC_STAGES-2:0], SS_n};
      mosi_sy <= {mosi_sy[SYNC_STAGES-2:0], MOSI};
      sck_d <= sck_s;
      ss_d <= ss_s;
    end
  assign sck_s = sck_sy[SYNC_STAGES-1];
  assign ss_s = ss_sy[SYNC_STAGES-1];
  assign mosi_s = mosi_sy[SYNC_STAGES-1];
  assign sck_rise = sck_s && !sck_d;
  assign sck_fall = !sck_s && sck_d;
  assign ss_fall = !ss_s && ss_d;
  assign ss_rise = ss_s && !ss_d;
  assign lead = cpol_q ? sck_fall : sck_rise;
  assign trail = cpol_q ? sck_rise : sck_fall;
  assign start = state == IDLE && ss_fall;
  assign stop = state == ACTIVE && ss_rise;
  assign sample_stb = state == ACTIVE && !ss_rise && (cpha_q ? trail : lead);
  assign shift_stb = state == ACTIVE && !ss_rise && (cpha_q ? lead : trail);
  // CPHA=0 must present the first bit before any SCK edge, so it loads on select itself
  assign load = (start && !CPHA) || (shift_stb && bit_cnt == '0 && load_due);
  assign accept = tx_valid && !hold_full;
  assign tx_ready = !hold_full;
  assign rx_nxt = LSB_FIRST != 0 ? {mosi_s, rx_shift[DATA_WIDTH-1:1]} : {rx_shift[DATA_WIDTH-2:0], mosi_s};
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_nxt;
  always_comb state_nxt = start ? ACTIVE : stop ? IDLE : state;
  always_comb begin
    busy = state == ACTIVE;
    MISO_oe = busy;
    MISO = busy && (LSB_FIRST != 0 ? tx_shift[0] : tx_shift[DATA_WIDTH-1]);
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      cpol_q <= 1'b0;
      cpha_q <= 1'b0;
      bit_cnt <= '0;
      load_due <= 1'b0;
      rx_shift <= '0;
      rx_data <= '0;
      rx_valid <= 1'b0;
      tx_shift <= '0;
      hold_data <= '0;
      hold_full <= 1'b0;
      underrun <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      underrun <= load && !hold_full;
      hold_full <= accept || (hold_full && !load);
      if (accept) hold_data <= tx_data;
      if (start) begin
        cpol_q <= CPOL;
        cpha_q <= CPHA;
        bit_cnt <= '0;
        load_due <= CPHA;
        rx_shift <= '0;
      end else if (stop) begin
        bit_cnt <= '0;
        load_due <= 1'b0;
        rx_shift <= '0;
      end else if (sample_stb) begin
        rx_shift <= rx_nxt;
        bit_cnt <= bit_cnt == LAST ? '0 : bit_cnt + 1'b1;
        if (bit_cnt == LAST) begin
          rx_data <= rx_nxt;
          rx_valid <= 1'b1;
          load_due <= 1'b1;
        end
      end else if (load) load_due <= 1'b0;
      if (load) tx_shift <= hold_full ? hold_data : '1;
      else if (shift_stb) tx_shift <= LSB_FIRST != 0 ? {1'b0, tx_shift[DATA_WIDTH-1:1]} : {tx_shift[DATA_WIDTH-2:0], 1'b0};
    end
endmodule

// File: tb/tb_spi_slave_shift_engine.sv
// tb_spi_slave_shift_engine: randomized SPI master against a frame-level slave model
module tb_spi_slave_shift_engine;
  localparam int H = 6;
  logic clk = 0, rst = 1, SCK_in = 0, SS_n = 1, MOSI = 0, CPOL = 0, CPHA = 0, tx_valid = 0;
  logic [7:0] tx_data = 0, rx_data;
  logic tx_ready, rx_valid, MISO, MISO_oe, busy, underrun;
  int vectors = 0, miscompares = 0, und_cnt = 0, exp_und = 0;
  logic [7:0] rx_q[$];
  logic m_hold_v = 0, mcpol = 0, mcpha = 0;
  logic [7:0] m_hold = 0, cur_exp = 0;
  spi_slave_shift_engine dut (
    .clk(clk), .rst(rst), .SCK_in(SCK_in), .SS_n(SS_n), .MOSI(MOSI), .CPOL(CPOL), .CPHA(CPHA),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready), .rx_data(rx_data), .rx_valid(rx_valid),
    .MISO(MISO), .MISO_oe(MISO_oe), .busy(busy), .underrun(underrun)
  );
  always #5 clk = ~clk;
  always @(negedge clk) begin
    if (rx_valid) rx_q.push_back(rx_data);
    if (underrun) und_cnt++;
  end
  function automatic logic [7:0] model_load();
    if (m_hold_v) begin
      m_hold_v = 0;
      return m_hold;
    end
    exp_und++;
    return 8'hFF;
  endfunction
  task automatic clks(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic offer(input logic [7:0] b);
    int t = 0;
    while (!tx_ready && t < 50) begin
      clks(1);
      t++;
    end
    vectors++;
    if (tx_ready !== 1'b1) begin
      $display("FAIL offer_wait tx_ready=%b required 1", tx_ready);
      miscompares++;
    end else begin
      tx_data = b;
      tx_valid = 1;
      clks(1);
      tx_valid = 0;
      m_hold_v = 1;
      m_hold = b;
    end
  endtask
  task automatic set_mode(input logic p, input logic h);
    mcpol = p;
    mcpha = h;
    CPOL = p;
    CPHA = h;
    SCK_in = p;
    clks(10);
  endtask
  task automatic ss_low();
    SS_n = 0;
    if (!mcpha) cur_exp = model_load();
    clks(8);
  endtask
  task automatic ss_high();
    clks(H);
    SS_n = 1;
    clks(8);
  endtask
  task automatic frame(input logic [7:0] m, input int n, output logic [7:0] s, output logic [7:0] e);
    s = 0;
    if (mcpha) cur_exp = model_load();
    e = cur_exp;
    for (int i = 0; i < n; i++)
      if (!mcpha) begin
        MOSI = m[7-i];
        clks(H);
        s[7-i] = MISO;
        SCK_in = ~mcpol;
        clks(H);
        SCK_in = mcpol;
        clks(H);
      end else begin
        SCK_in = ~mcpol;
        clks(H);
        MOSI = m[7-i];
        clks(H);
        s[7-i] = MISO;
        SCK_in = mcpol;
        clks(H);
      end
    if (!mcpha && n == 8) cur_exp = model_load();
  endtask
  task automatic test_reset();
    vectors++;
    if ({rx_valid, tx_ready, MISO, MISO_oe, busy, underrun} !== 6'b010000) begin
      $display("FAIL reset_flags got %b required 010000", {rx_valid, tx_ready, MISO, MISO_oe, busy, underrun});
      miscompares++;
    end
    vectors++;
    if (rx_data !== 8'h00) begin
      $display("FAIL reset_rx_data got %h required 00", rx_data);
      miscompares++;
    end
  endtask
  task automatic test_mode0();
    logic [7:0] s, e, got;
    int n0;
    set_mode(0, 0);
    offer(8'hA5);
    vectors++;
    if (tx_ready !== 1'b0) begin
      $display("FAIL mode0_hold_full tx_ready=%b required 0", tx_ready);
      miscompares++;
    end
    n0 = rx_q.size();
    ss_low();
    vectors++;
    if ({busy, MISO_oe, tx_ready} !== 3'b111) begin
      $display("FAIL mode0_active busy/oe/tx_ready=%b required 111", {busy, MISO_oe, tx_ready});
      miscompares++;
    end
    frame(8'h3C, 8, s, e);
    ss_high();
    vectors++;
    if (s !== 8'hA5) begin
      $display("FAIL mode0_miso got %h required a5", s);
      miscompares++;
    end
    got = rx_q.size() > n0 ? rx_q[n0] : 8'hxx;
    vectors++;
    if (rx_q.size() != n0 + 1 || got !== 8'h3C) begin
      $display("FAIL mode0_rx got %h (%0d pulses) required 3c (1 pulse)", got, rx_q.size() - n0);
      miscompares++;
    end
    vectors++;
    if ({busy, MISO_oe, MISO} !== 3'b000 || und_cnt != exp_und) begin
      $display("FAIL mode0_idle busy/oe/miso=%b underruns=%0d required 000 underruns=%0d", {busy, MISO_oe, MISO}, und_cnt, exp_und);
      miscompares++;
    end
  endtask
  task automatic test_modes();
    logic [7:0] s, e, got;
    int n0;
    for (int md = 1; md < 4; md++) begin
      set_mode(md[1], md[0]);
      offer(8'h5A);
      n0 = rx_q.size();
      ss_low();
      frame(8'hC3, 8, s, e);
      ss_high();
      vectors++;
      if (s !== 8'h5A) begin
        $display("FAIL mode%0d_miso got %h required 5a", md, s);
        miscompares++;
      end
      got = rx_q.size() > n0 ? rx_q[n0] : 8'hxx;
      vectors++;
      if (rx_q.size() != n0 + 1 || got !== 8'hC3) begin
        $display("FAIL mode%0d_rx got %h (%0d pulses) required c3", md, got, rx_q.size() - n0);
        miscompares++;
      end
      vectors++;
      if (und_cnt != exp_und) begin
        $display("FAIL mode%0d_underrun got %0d required %0d", md, und_cnt, exp_und);
        miscompares++;
      end
    end
  endtask
  task automatic test_underrun();
    logic [7:0] s, e, m, got;
    int n0, u0;
    m = 8'($urandom);
    set_mode(0, 1);
    n0 = rx_q.size();
    u0 = und_cnt;
    ss_low();
    frame(m, 8, s, e);
    ss_high();
    vectors++;
    if (s !== 8'hFF) begin
      $display("FAIL underrun_miso got %h required ff", s);
      miscompares++;
    end
    vectors++;
    if (und_cnt != u0 + 1) begin
      $display("FAIL underrun_pulses got %0d required 1", und_cnt - u0);
      miscompares++;
    end
    got = rx_q.size() > n0 ? rx_q[n0] : 8'hxx;
    vectors++;
    if (rx_q.size() != n0 + 1 || got !== m) begin
      $display("FAIL underrun_rx got %h required %h", got, m);
      miscompares++;
    end
    exp_und = und_cnt;
  endtask
  task automatic test_back_to_back();
    logic [7:0] s1, s2, e;
    int n0;
    set_mode(0, 0);
    offer(8'h11);
    n0 = rx_q.size();
    ss_low();
    offer(8'h22);
    frame(8'h81, 8, s1, e);
    frame(8'h42, 8, s2, e);
    ss_high();
    vectors++;
    if (s1 !== 8'h11 || s2 !== 8'h22) begin
      $display("FAIL b2b_miso got %h,%h required 11,22", s1, s2);
      miscompares++;
    end
    vectors++;
    if (rx_q.size() != n0 + 2 || rx_q[n0] !== 8'h81 || rx_q[n0+1] !== 8'h42) begin
      $display("FAIL b2b_rx pulses=%0d required 2 frames 81,42", rx_q.size() - n0);
      miscompares++;
    end
    vectors++;
    if (und_cnt != exp_und) begin
      $display("FAIL b2b_underrun got %0d required %0d", und_cnt, exp_und);
      miscompares++;
    end
  endtask
  task automatic test_abort();
    logic [7:0] s, e, b, c, m, got;
    int n0;
    b = 8'($urandom);
    c = 8'($urandom);
    m = 8'($urandom);
    set_mode(0, 0);
    offer(b);
    n0 = rx_q.size();
    ss_low();
    frame(8'($urandom), 5, s, e);
    ss_high();
    vectors++;
    if (s[7:3] !== b[7:3]) begin
      $display("FAIL abort_miso got %b required %b", s[7:3], b[7:3]);
      miscompares++;
    end
    vectors++;
    if (rx_q.size() != n0 || {busy, MISO_oe, MISO} !== 3'b000) begin
      $display("FAIL abort_idle pulses=%0d busy/oe/miso=%b required 0 and 000", rx_q.size() - n0, {busy, MISO_oe, MISO});
      miscompares++;
    end
    offer(c);
    ss_low();
    frame(m, 8, s, e);
    ss_high();
    got = rx_q.size() > n0 ? rx_q[n0] : 8'hxx;
    vectors++;
    if (s !== c || rx_q.size() != n0 + 1 || got !== m) begin
      $display("FAIL abort_next miso=%h rx=%h required miso=%h rx=%h", s, got, c, m);
      miscompares++;
    end
    vectors++;
    if (und_cnt != exp_und) begin
      $display("FAIL abort_underrun got %0d required %0d", und_cnt, exp_und);
      miscompares++;
    end
  endtask
  task automatic test_random();
    logic [7:0] s, e, m, b, got;
    logic p, h, off;
    int n0;
    for (int k = 0; k < 16; k++) begin
      p = 1'($urandom);
      h = 1'($urandom);
      off = 1'($urandom);
      m = 8'($urandom);
      b = 8'($urandom);
      set_mode(p, h);
      if (off) offer(b);
      n0 = rx_q.size();
      ss_low();
      CPOL = ~p;
      CPHA = ~h;
      frame(m, 8, s, e);
      ss_high();
      vectors++;
      if (s !== e) begin
        $display("FAIL rand%0d_miso mode=%b%b got %h required %h", k, p, h, s, e);
        miscompares++;
      end
      got = rx_q.size() > n0 ? rx_q[n0] : 8'hxx;
      vectors++;
      if (rx_q.size() != n0 + 1 || got !== m) begin
        $display("FAIL rand%0d_rx mode=%b%b got %h required %h", k, p, h, got, m);
        miscompares++;
      end
      vectors++;
      if (und_cnt != exp_und) begin
        $display("FAIL rand%0d_underrun got %0d required %0d", k, und_cnt, exp_und);
        miscompares++;
      end
    end
  endtask
  task automatic test_async_reset();
    logic [7:0] s, e;
    int n0;
    set_mode(0, 0);
    offer(8'($urandom));
    n0 = rx_q.size();
    ss_low();
    frame(8'($urandom), 3, s, e);
    @(posedge clk);
    #2 rst = 1;
    #1;
    vectors++;
    if ({busy, MISO_oe, MISO, rx_valid, underrun, tx_ready} !== 6'b000001 || rx_data !== 8'h00) begin
      $display("FAIL async_reset flags=%b rx_data=%h required 000001 and 00", {busy, MISO_oe, MISO, rx_valid, underrun, tx_ready}, rx_data);
      miscompares++;
    end
    SS_n = 1;
    SCK_in = 0;
    MOSI = 0;
    m_hold_v = 0;
    clks(4);
    rst = 0;
    clks(10);
    vectors++;
    if (rx_q.size() != n0 || tx_ready !== 1'b1) begin
      $display("FAIL async_reset_after pulses=%0d tx_ready=%b required 0 and 1", rx_q.size() - n0, tx_ready);
      miscompares++;
    end
  endtask
  initial begin
    #1000000;
    $display("FAIL global_timeout simulation did not complete");
    miscompares++;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
  initial begin
    clks(5);
    rst = 0;
    clks(3);
    test_reset();
    test_mode0();
    test_modes();
    test_underrun();
    test_back_to_back();
    test_abort();
    test_random();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
